// File: rtl/traffic_phase_scheduler_pkg.sv
// traffic_phase_scheduler_pkg: state codes, lamp patterns and width helpers shared by the scheduler.
package traffic_phase_scheduler_pkg;
    localparam logic [2:0] HG = 3'd0, HY = 3'd1, ARH = 3'd2, FG = 3'd3, FY = 3'd4, ARF = 3'd5, PED = 3'd6;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    function automatic int tick_bits(input int div);
        return $clog2(div);
    endfunction

    function automatic int timer_bits(input int a, input int b, input int c, input int d, input int e);
        int m;
        m = a > b ? a : b;
        m = m > c ? m : c;
        m = m > d ? m : d;
        m = m > e ? m : e;
        return $clog2(m) + 1;
    endfunction

    // {highway, farm, walk} shown while in a given state
    function automatic logic [6:0] lamps(input logic [2:0] s);
        return s == HG  ? {GRN, RED, 1'b0} :
               s == HY  ? {YEL, RED, 1'b0} :
               s == FG  ? {RED, GRN, 1'b0} :
               s == FY  ? {RED, YEL, 1'b0} :
               s == PED ? {RED, RED, 1'b1} : {RED, RED, 1'b0};
    endfunction
endpackage

// File: rtl/traffic_phase_scheduler_tick_gen.sv
// tick_gen: free-running prescaler producing a one-clk tick every TICK_DIV clks.
module tick_gen
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int W = tick_bits(TICK_DIV);
    logic [W-1:0] cnt;

    assign tick = cnt == W'(TICK_DIV - 1);

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/traffic_phase_scheduler.sv
// traffic_phase_scheduler: highway/farm/pedestrian phase sequencer stepped by a one-second tick.
module traffic_phase_scheduler
    import traffic_phase_scheduler_pkg::*;
#(
    parameter int TICK_DIV  = 50000000,
    parameter int GREEN_MIN = 10,
    parameter int YELLOW_T  = 3,
    parameter int ALL_RED_T = 1,
    parameter int FARM_MAX  = 9,
    parameter int WALK_T    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       v,
    input  logic       ped_req,
    output logic [2:0] highway,
    output logic [2:0] farm,
    output logic       walk,
    output logic       ped_ack,
    output logic [2:0] phase
);
    localparam int TW = timer_bits(GREEN_MIN, YELLOW_T, ALL_RED_T, FARM_MAX, WALK_T);

    logic          tick, pend, fin, enter_ped;
    logic [2:0]    state, nxt;
    logic [TW-1:0] timer, lim;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(tick));

    assign phase     = state;
    assign enter_ped = nxt == PED && state != PED;

    // fixed-length phases share one end-of-phase compare
    always_comb begin
        lim = (state == HY || state == FY) ? TW'(YELLOW_T - 1) :
              state == PED                 ? TW'(WALK_T - 1)   : TW'(ALL_RED_T - 1);
        fin = tick && timer == lim;
        nxt = state;
        case (state)
            HG:      if (tick && timer >= TW'(GREEN_MIN - 1) && (v || pend)) nxt = HY;
            HY:      if (fin) nxt = ARH;
            ARH:     if (fin) nxt = pend ? PED : v ? FG : HG;
            FG:      if (tick && (!v || timer == TW'(FARM_MAX - 1))) nxt = FY;
            FY:      if (fin) nxt = ARF;
            ARF:     if (fin) nxt = pend ? PED : HG;
            PED:     if (fin) nxt = HG;
            default: nxt = HG;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state                  <= HG;
            timer                  <= '0;
            pend                   <= 1'b0;
            ped_ack                <= 1'b0;
            {highway, farm, walk}  <= lamps(HG);
        end else begin
            state                  <= nxt;
            timer                  <= nxt != state ? '0 : (tick && timer != '1) ? timer + 1'b1 : timer;
            ped_ack                <= enter_ped;
            pend                   <= enter_ped ? 1'b0 : (ped_req && state != PED) ? 1'b1 : pend;
            {highway, farm, walk}  <= lamps(nxt);
        end
endmodule
